// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the branch operand forwarding path:
// operand source selects and the stall-tracking FSM states.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_STALLING = 1'b1
   } stall_state_e;

endpackage

// File: rtl/fwd_operand_mux.sv
// Resolves one branch source operand from the regfile, EX or MEM stage,
// and flags when the value is not yet available.
module fwd_operand_mux
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              branch,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_data,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_wr_addr,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              mem_wr_en,
   input  logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_wr_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   output logic [DATA_W-1:0] op_out,
   output logic [1:0]        fwd_sel,
   output logic              stall_req
);

   logic nonzero;
   logic ex_hit;
   logic mem_hit;

   assign nonzero = (op_addr != '0);
   assign ex_hit  = branch & ex_wr_en  & (ex_wr_addr  == op_addr) & nonzero;
   assign mem_hit = branch & mem_wr_en & (mem_wr_addr == op_addr) & nonzero;

   // A load in EX shadows any older MEM write to the same register.
   always_comb begin
      op_out    = op_data;
      fwd_sel   = FWD_RF;
      stall_req = 1'b0;
      if (ex_hit) begin
         if (ex_is_load) begin
            stall_req = 1'b1;
         end else begin
            op_out  = ex_result;
            fwd_sel = FWD_EX;
         end
      end else if (mem_hit) begin
         if (mem_ready) begin
            op_out  = mem_wr_data;
            fwd_sel = FWD_MEM;
         end else begin
            stall_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_fwd_ctrl.sv
// Branch operand forwarding and stall control for the ID stage, with
// consecutive-stall watchdog and a saturating stall performance counter.
module branch_fwd_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_OPS   = 2,
   parameter int MAX_STALL = 3,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      branch,
   input  logic                      flush,
   input  logic [NUM_OPS*ADDR_W-1:0] op_addr,
   input  logic [NUM_OPS*DATA_W-1:0] op_data,
   input  logic                      ex_wr_en,
   input  logic                      ex_is_load,
   input  logic [ADDR_W-1:0]         ex_wr_addr,
   input  logic [DATA_W-1:0]         ex_result,
   input  logic                      mem_wr_en,
   input  logic                      mem_ready,
   input  logic [ADDR_W-1:0]         mem_wr_addr,
   input  logic [DATA_W-1:0]         mem_wr_data,
   output logic [NUM_OPS*DATA_W-1:0] op_out,
   output logic [NUM_OPS*2-1:0]      fwd_sel,
   output logic                      stall,
   output logic                      hazard_err,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int CONS_W = $clog2(MAX_STALL + 1);
   localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_STALL);

   logic [NUM_OPS-1:0] stall_req;
   stall_state_e       state_q, state_d;
   logic [CONS_W-1:0]  consec_q, consec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               herr_q, herr_d;

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_operand_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_mux (
         .branch      (branch),
         .op_addr     (op_addr[g*ADDR_W +: ADDR_W]),
         .op_data     (op_data[g*DATA_W +: DATA_W]),
         .ex_wr_en    (ex_wr_en),
         .ex_is_load  (ex_is_load),
         .ex_wr_addr  (ex_wr_addr),
         .ex_result   (ex_result),
         .mem_wr_en   (mem_wr_en),
         .mem_ready   (mem_ready),
         .mem_wr_addr (mem_wr_addr),
         .mem_wr_data (mem_wr_data),
         .op_out      (op_out[g*DATA_W +: DATA_W]),
         .fwd_sel     (fwd_sel[g*2 +: 2]),
         .stall_req   (stall_req[g])
      );
   end

   // Flush and reset both veto the stall in the same cycle.
   assign stall = (|stall_req) & ~flush & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         consec_q <= '0;
         cnt_q    <= '0;
         herr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         consec_q <= consec_d;
         cnt_q    <= cnt_d;
         herr_q   <= herr_d;
      end
   end

   // Entering STALLING always restarts the run at one, so a stall directly
   // after a flush or a clean cycle never inherits an old run length.
   always_comb begin
      state_d  = ST_IDLE;
      consec_d = '0;
      cnt_d    = cnt_q;
      herr_d   = herr_q;
      if (stall) begin
         state_d = ST_STALLING;
         if (state_q == ST_IDLE) begin
            consec_d = CONS_W'(1);
         end else if (consec_q == CONS_MAX) begin
            consec_d = consec_q;
         end else begin
            consec_d = consec_q + CONS_W'(1);
         end
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (consec_d == CONS_MAX) begin
            herr_d = 1'b1;
         end
      end
   end

   assign hazard_err = herr_q;
   assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Directed bench for branch_fwd_ctrl: expected outputs are queued when each
// step is driven and checked when the DUT result is sampled.
module tb_branch_fwd_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NO = 2;
   localparam int MS = 3;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              branch, flush;
   logic [NO*AW-1:0]  op_addr;
   logic [NO*DW-1:0]  op_data;
   logic              ex_wr_en, ex_is_load;
   logic [AW-1:0]     ex_wr_addr;
   logic [DW-1:0]     ex_result;
   logic              mem_wr_en, mem_ready;
   logic [AW-1:0]     mem_wr_addr;
   logic [DW-1:0]     mem_wr_data;
   logic [NO*DW-1:0]  op_out;
   logic [NO*2-1:0]   fwd_sel;
   logic              stall, hazard_err;
   logic [CW-1:0]     stall_cnt;

   branch_fwd_ctrl #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .NUM_OPS   (NO),
      .MAX_STALL (MS),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .branch      (branch),
      .flush       (flush),
      .op_addr     (op_addr),
      .op_data     (op_data),
      .ex_wr_en    (ex_wr_en),
      .ex_is_load  (ex_is_load),
      .ex_wr_addr  (ex_wr_addr),
      .ex_result   (ex_result),
      .mem_wr_en   (mem_wr_en),
      .mem_ready   (mem_ready),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .op_out      (op_out),
      .fwd_sel     (fwd_sel),
      .stall       (stall),
      .hazard_err  (hazard_err),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            tag;
      logic [NO*DW-1:0] op;
      logic [NO*2-1:0]  sel;
      logic             stl;
      logic [CW-1:0]    cnt;
      logic             herr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   m_consec = 0;
   int   m_cnt    = 0;
   bit   m_herr   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      branch = 1'b0; flush = 1'b0;
      op_addr = '0; op_data = '0;
      ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0; ex_result = '0;
      mem_wr_en = 1'b0; mem_ready = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
   endtask

   // Reference for the current inputs; also advances the register model.
   task automatic push_expected(input string tag);
      exp_t e;
      e.tag = tag; e.op = op_data; e.sel = '0; e.stl = 1'b0;
      for (int i = 0; i < NO; i++) begin
         logic [AW-1:0] a;
         bit exm, memm;
         a    = op_addr[i*AW +: AW];
         exm  = branch && ex_wr_en  && ex_wr_addr  == a && a != 0;
         memm = branch && mem_wr_en && mem_wr_addr == a && a != 0;
         if (exm && ex_is_load) e.stl = 1'b1;
         else if (exm) begin e.op[i*DW +: DW] = ex_result; e.sel[i*2 +: 2] = 2'b01; end
         else if (memm && mem_ready) begin e.op[i*DW +: DW] = mem_wr_data; e.sel[i*2 +: 2] = 2'b10; end
         else if (memm) e.stl = 1'b1;
      end
      if (flush) e.stl = 1'b0;
      if (e.stl) begin
         m_consec = (m_consec < MS) ? m_consec + 1 : MS;
         m_cnt    = (m_cnt < 15) ? m_cnt + 1 : 15;
         if (m_consec == MS) m_herr = 1'b1;
      end else begin
         m_consec = 0;
      end
      e.cnt = CW'(m_cnt); e.herr = m_herr;
      sb.push_back(e);
   endtask

   task automatic step(input string tag);
      exp_t e;
      push_expected(tag);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_op"},    64'(op_out),  64'(e.op));
         chk({e.tag, "_sel"},   64'(fwd_sel), 64'(e.sel));
         chk({e.tag, "_stall"}, 64'(stall),   64'(e.stl));
         @(posedge clk); #1;
         chk({e.tag, "_cnt"},   64'(stall_cnt),  64'(e.cnt));
         chk({e.tag, "_herr"},  64'(hazard_err), 64'(e.herr));
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      #2;
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_cnt",   64'(stall_cnt), 64'd0);
      chk("rst_herr",  64'(hazard_err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // EX forwarding to rt
      branch = 1'b1; op_addr = {5'd8, 5'd3}; op_data = {32'h22, 32'h11};
      ex_wr_en = 1'b1; ex_wr_addr = 5'd8; ex_result = 32'h1234;
      step("ex_fwd");
      chk("ex_fwd_const", 64'(op_out[DW +: DW]), 64'h1234);

      // EX has priority over MEM for the same register
      ex_result = 32'hA; mem_wr_en = 1'b1; mem_ready = 1'b1;
      mem_wr_addr = 5'd8; mem_wr_data = 32'hB;
      step("ex_prio");

      // r0 is never forwarded
      op_addr = '0; ex_wr_addr = 5'd0; ex_result = 32'hFF; mem_wr_addr = 5'd0;
      step("r0");

      // MEM forwarding to rs, other operand from regfile
      clear_inputs();
      branch = 1'b1; op_addr = {5'd7, 5'd5}; op_data = {32'h7777, 32'h5555};
      mem_wr_en = 1'b1; mem_ready = 1'b1; mem_wr_addr = 5'd5; mem_wr_data = 32'hBEEF;
      step("mem_fwd");

      // no branch: load hazard ignored
      clear_inputs();
      op_addr = {5'd4, 5'd9}; op_data = {32'h44, 32'h99};
      ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd9;
      step("no_branch");

      // load-use: one stall, then MEM forward
      branch = 1'b1;
      step("load_stall");
      ex_wr_en = 1'b0; ex_is_load = 1'b0;
      mem_wr_en = 1'b1; mem_ready = 1'b1; mem_wr_addr = 5'd9; mem_wr_data = 32'hC0DE;
      step("load_mem_fwd");

      // MEM not ready for MAX_STALL cycles trips the watchdog
      mem_ready = 1'b0;
      for (int i = 0; i < MS; i++) step("mem_wait");

      // flush beats a live stall condition; counters keep their values
      flush = 1'b1;
      step("flush");
      flush = 1'b0;
      step("post_flush_stall");

      // async reset mid-stall
      rst = 1'b1;
      #1;
      chk("midrst_stall", 64'(stall), 64'd0);
      chk("midrst_cnt",   64'(stall_cnt), 64'd0);
      chk("midrst_herr",  64'(hazard_err), 64'd0);
      m_consec = 0; m_cnt = 0; m_herr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // fresh stall run long enough to saturate a 4-bit counter
      for (int i = 0; i < 17; i++) step("sat");
      chk("sat_const", 64'(stall_cnt), 64'd15);

      clear_inputs();
      step("idle_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_fwd_ctrl.md
BRANCH_FWD_CTRL -- requirements
Module: branch_fwd_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of operand and result data.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of register addresses.
REQ-003 Parameter NUM_OPS, default 2, SHALL set the number of branch source operands (0 = rs, 1 = rt).
REQ-004 Parameter MAX_STALL, default 3, SHALL set the consecutive-stall limit that raises hazard_err.
REQ-005 Parameter CNT_W, default 16, SHALL set the stall performance counter width.
REQ-006 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-008 branch  in  1  SHALL indicate that a branch in ID needs its operands this cycle.
REQ-009 flush  in  1  SHALL indicate a pipeline flush this cycle.
REQ-010 op_addr  in  NUM_OPS*ADDR_W  SHALL carry the packed source register addresses.
REQ-011 op_data  in  NUM_OPS*DATA_W  SHALL carry the packed register-file read data.
REQ-012 ex_wr_en, ex_is_load  in  1 each  SHALL carry the EX-stage write enable and load flag.
REQ-013 ex_wr_addr  in  ADDR_W; ex_result  in  DATA_W  SHALL carry the EX destination and ALU result.
REQ-014 mem_wr_en, mem_ready  in  1 each  SHALL carry the MEM-stage write enable and data-valid flag.
REQ-015 mem_wr_addr  in  ADDR_W; mem_wr_data  in  DATA_W  SHALL carry the MEM destination and write-back data.
REQ-016 op_out  out  NUM_OPS*DATA_W  SHALL carry the resolved operands.
REQ-017 fwd_sel  out  NUM_OPS*2  SHALL carry the per-operand source: 00 regfile, 01 EX, 10 MEM.
REQ-018 stall  out  1  SHALL request that the IF/ID stages hold.
REQ-019 hazard_err  out  1  SHALL be the sticky stall-limit error flag.
REQ-020 stall_cnt  out  CNT_W  SHALL carry the saturating count of stall cycles.

Function
REQ-021 Per operand i, EX match SHALL be branch & ex_wr_en & (ex_wr_addr == op_addr[i]) & (op_addr[i] != 0).
REQ-022 MEM match SHALL be defined identically with mem_wr_en / mem_wr_addr.
REQ-023 An EX match SHALL take priority over a MEM match; with no match, op_out[i] = op_data[i] and fwd_sel = 00.
REQ-024 An EX match with ex_is_load = 0 SHALL forward ex_result (fwd_sel 01).
REQ-025 An EX match with ex_is_load = 1 SHALL assert stall; op_out[i] then = op_data[i] and fwd_sel = 00.
REQ-026 A MEM match (no EX match) with mem_ready = 1 SHALL forward mem_wr_data (fwd_sel 10); with mem_ready = 0 it SHALL assert stall.
REQ-027 stall SHALL be combinational, with zero-cycle latency from inputs, and SHALL be the OR over all operands; it SHALL be 0 whenever branch = 0, flush = 1 or rst = 1.
REQ-028 FSM states: IDLE and STALLING; IDLE->STALLING when stall = 1; STALLING->IDLE when stall = 0; a 1-cycle stall SHALL count as one STALLING cycle.
REQ-029 A consecutive-stall counter SHALL increment on each cycle with stall = 1, clear to 0 on each cycle with stall = 0, and saturate at MAX_STALL.
REQ-030 hazard_err SHALL set on the edge where the consecutive counter reaches MAX_STALL, and SHALL clear only on rst.
REQ-031 stall_cnt SHALL increment by 1 per stall cycle and saturate at all-ones without wrapping.
REQ-032 flush = 1 SHALL force state IDLE and clear the consecutive counter on the next edge; stall_cnt and hazard_err SHALL be unaffected.
REQ-033 Simultaneous flush and a stall condition: flush SHALL win, so stall = 0 and no count is taken.

Reset
REQ-034 While rst = 1: state = IDLE, consecutive counter = 0, stall_cnt = 0, hazard_err = 0, stall = 0.
REQ-035 Reset asserted mid-stall SHALL abort the stall immediately; the first post-reset cycle SHALL evaluate fresh inputs.

Structure
REQ-036 The fwd_sel encodings and FSM state encodings SHALL live in a shared package (mips_pipe_pkg).
REQ-037 Per-operand match/mux logic SHALL be one sub-module, fwd_operand_mux, instantiated NUM_OPS times by generate.

Verification
REQ-038 branch = 1, op_addr[1] = 8, ex_wr_en = 1, ex_wr_addr = 8, ex_result = 0x1234 -> op_out[1] = 0x1234, fwd_sel[1] = 01, stall = 0.
REQ-039 EX and MEM both target r8, with ex_result = 0xA and mem_wr_data = 0xB -> op_out = 0xA (EX priority).
REQ-040 op_addr = 0, with EX writing r0 = 0xFF -> op_out = op_data, fwd_sel = 00.
REQ-041 EX load to r9, op_addr[0] = 9, held 1 cycle, then MEM match with mem_ready = 1 -> stall for 1 cycle, then forward mem_wr_data; stall_cnt = 1, hazard_err = 0.
REQ-042 MEM match with mem_ready = 0 held 3 cycles (MAX_STALL = 3) -> stall high 3 cycles, hazard_err = 1 after the 3rd edge; flush then clears stall, and hazard_err stays 1.
REQ-043 rst pulsed mid-stall with stall_cnt = 5 -> all outputs read 0 immediately; stall_cnt saturation test with CNT_W = 4 -> holds at 15.
